// File: rtl/ram_sp_rr_arbiter.sv
// Round-robin arbiter sharing one single-port byte-write RAM between N_PORTS requesters,
// with an optional zero sweep of the whole RAM after reset.
module ram_sp_rr_arbiter #(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned DATA_BITS      = 64,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS-1:0]                req_valid,
  output logic [N_PORTS-1:0]                req_ready,
  input  logic [N_PORTS*DATA_BITS/8-1:0]    req_we,
  input  logic [N_PORTS*ADDR_BITS-1:0]      req_addr,
  input  logic [N_PORTS*DATA_BITS-1:0]      req_data,
  output logic [N_PORTS-1:0]                rsp_valid,
  output logic [DATA_BITS-1:0]              rsp_data,
  output logic                              init_done,
  output logic                              ram_en,
  output logic [DATA_BITS/8-1:0]            ram_we,
  output logic [ADDR_BITS-1:0]              ram_addr,
  output logic [DATA_BITS-1:0]              ram_data_in,
  input  logic [DATA_BITS-1:0]              ram_data_out
);

  localparam int unsigned BE_BITS = DATA_BITS / 8;
  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W   = ADDR_BITS + 1;
  localparam int unsigned PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 ram_en_q, ram_en_d;
  logic [BE_BITS-1:0]   ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_BITS-1:0] ram_data_q, ram_data_d;
  logic [N_PORTS-1:0]   rd_port_q, rd_port_d;
  logic [N_PORTS-1:0]   rsp_valid_q;
  logic                 init_done_q, init_done_d;

  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     cand;

  logic [BE_BITS-1:0]   we_a   [N_PORTS];
  logic [ADDR_BITS-1:0] addr_a [N_PORTS];
  logic [DATA_BITS-1:0] data_a [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign we_a[g]   = req_we[g*BE_BITS +: BE_BITS];
    assign addr_a[g] = req_addr[g*ADDR_BITS +: ADDR_BITS];
    assign data_a[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned k = 1; k <= N_PORTS; k++) begin
        cand = PTR_W'((32'(ptr_q) + k) % N_PORTS);
        if (!gnt_found && req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Next-state: clear sweep, then registered RAM command from the granted port.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ptr_d      = ptr_q;
    ram_en_d   = 1'b0;
    ram_we_d   = '0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    rd_port_d  = '0;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == CNT_W'(DEPTH)) begin
          state_d = ST_RUN;
        end else begin
          ram_en_d   = 1'b1;
          ram_we_d   = '1;
          ram_addr_d = clr_cnt_q[ADDR_BITS-1:0];
          ram_data_d = '0;
          clr_cnt_d  = clr_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (gnt_found) begin
          ptr_d              = gnt_idx;
          ram_en_d           = 1'b1;
          ram_we_d           = we_a[gnt_idx];
          ram_addr_d         = addr_a[gnt_idx];
          ram_data_d         = data_a[gnt_idx];
          rd_port_d[gnt_idx] = (we_a[gnt_idx] == '0);
        end
      end
      default: state_d = RST_STATE;
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      ptr_q       <= PTR_W'(N_PORTS - 1);
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      rd_port_q   <= '0;
      rsp_valid_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ptr_q       <= ptr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      rd_port_q   <= rd_port_d;
      rsp_valid_q <= rd_port_q;
      init_done_q <= init_done_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = ram_data_out;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_ram_sp_rr_arbiter.sv
// Directed bench for ram_sp_rr_arbiter: 2 ports, 16-entry RAM, clear-on-reset enabled,
// with a behavioural byte-write RAM (1-cycle registered read, old data on write).
module tb_ram_sp_rr_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AB = 4;
  localparam int unsigned DB = 64;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [15:0]     req_we;
  logic [7:0]      req_addr;
  logic [127:0]    req_data;
  logic [NP-1:0]   rsp_valid;
  logic [63:0]     rsp_data;
  logic            init_done;
  logic            ram_en;
  logic [7:0]      ram_we;
  logic [3:0]      ram_addr;
  logic [63:0]     ram_data_in;
  logic [63:0]     ram_data_out;

  int n_total = 0;
  int n_bad   = 0;

  ram_sp_rr_arbiter #(
    .N_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, preloaded with ones so the clear sweep is observable.
  logic [63:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '1;
    ram_data_out = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      ram_data_out <= mem[ram_addr];
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_data_in[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request on port p and return at the negedge after its handshake.
  task automatic issue(input int p, input logic [7:0] we, input logic [3:0] addr,
                       input logic [63:0] data);
    int waited;
    waited = 0;
    req_valid[p]         = 1'b1;
    req_we[p*8 +: 8]     = we;
    req_addr[p*4 +: 4]   = addr;
    req_data[p*64 +: 64] = data;
    #1;
    while (!req_ready[p] && waited < 8) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    check("grant", 64'(req_ready[p]), 64'd1);
    @(posedge clk); @(negedge clk);
    req_valid[p] = 1'b0;
  endtask

  logic [1:0] rr_tbl [6];
  int spurious;
  int budget;

  initial begin
    rr_tbl[0] = 2'b01; rr_tbl[1] = 2'b10; rr_tbl[2] = 2'b01;
    rr_tbl[3] = 2'b10; rr_tbl[4] = 2'b01; rr_tbl[5] = 2'b10;
    rst = 1'b1; req_valid = 2'b11; req_we = '0; req_addr = '0; req_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);

    // Clear sweep over addresses 0..15, requests held off
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); @(negedge clk);
      check("clr_en", 64'(ram_en), 64'd1);
      check("clr_we", 64'(ram_we), 64'hFF);
      check("clr_addr", 64'(ram_addr), 64'(k));
      check("clr_data", ram_data_in, 64'd0);
      check("clr_ready", 64'(req_ready), 64'd0);
      check("clr_init", 64'(init_done), 64'd0);
    end
    @(posedge clk); @(negedge clk);
    check("run_init_done", 64'(init_done), 64'd1);
    check("run_ram_en", 64'(ram_en), 64'd0);
    check("run_first_prio", 64'(req_ready), 64'b01);
    req_valid = 2'b00;
    @(posedge clk); @(negedge clk);

    // Write then read same address on consecutive grants
    issue(0, 8'hFF, 4'd5, 64'h0000_0000_DEAD_BEEF);
    check("wr_en", 64'(ram_en), 64'd1);
    check("wr_we", 64'(ram_we), 64'hFF);
    check("wr_addr", 64'(ram_addr), 64'd5);
    check("wr_data", ram_data_in, 64'h0000_0000_DEAD_BEEF);
    issue(0, 8'h00, 4'd5, 64'd0);
    check("rd_we", 64'(ram_we), 64'd0);
    check("rd_rsp_early", 64'(rsp_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check("rd_rsp_valid", 64'(rsp_valid), 64'b01);
    check("rd_rsp_data", rsp_data, 64'h0000_0000_DEAD_BEEF);
    check("rd_ram_idle", 64'(ram_en), 64'd0);
    @(posedge clk); @(negedge clk);
    check("rd_rsp_once", 64'(rsp_valid), 64'd0);

    // Partial byte write into a cleared word
    issue(1, 8'h01, 4'd3, 64'h1234_5678_9ABC_DEAB);
    issue(1, 8'h00, 4'd3, 64'd0);
    @(posedge clk); @(negedge clk);
    check("pw_rsp_valid", 64'(rsp_valid), 64'b10);
    check("pw_rsp_data", rsp_data, 64'h0000_0000_0000_00AB);

    // Both ports continuously valid: grants alternate
    req_we = 16'hFFFF; req_addr = 8'h98;
    req_data = {64'h2222, 64'h1111};
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rr_grant", 64'(req_ready), 64'(rr_tbl[i]));
      @(posedge clk); @(negedge clk);
    end
    req_valid = 2'b00; req_we = '0;
    @(posedge clk); @(negedge clk);

    // Back-to-back reads from ports 0,1,0
    req_valid = 2'b01; req_addr = 8'h05; #1;
    check("b2b_g0", 64'(req_ready), 64'b01);
    @(posedge clk); @(negedge clk);
    req_valid = 2'b10; req_addr = 8'h35; #1;
    check("b2b_g1", 64'(req_ready), 64'b10);
    check("b2b_rsp_none", 64'(rsp_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    req_valid = 2'b01; req_addr = 8'h38; #1;
    check("b2b_g2", 64'(req_ready), 64'b01);
    check("b2b_rsp0", 64'(rsp_valid), 64'b01);
    check("b2b_data0", rsp_data, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    check("b2b_rsp1", 64'(rsp_valid), 64'b10);
    check("b2b_data1", rsp_data, 64'h0000_0000_0000_00AB);
    @(posedge clk); @(negedge clk);
    check("b2b_rsp2", 64'(rsp_valid), 64'b01);
    check("b2b_data2", rsp_data, 64'h1111);
    @(posedge clk); @(negedge clk);
    check("b2b_rsp_end", 64'(rsp_valid), 64'd0);

    // Read in flight cancelled by reset; sweep restarts at 0
    req_valid = 2'b10; req_addr = 8'h30; #1;
    check("rr_rst_grant", 64'(req_ready), 64'b10);
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rr_rst_rsp", 64'(rsp_valid), 64'd0);
    check("rr_rst_init", 64'(init_done), 64'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rr_rst_addr0", 64'(ram_addr), 64'd0);
    check("rr_rst_en", 64'(ram_en), 64'd1);
    @(posedge clk); @(negedge clk);
    check("rr_rst_addr1", 64'(ram_addr), 64'd1);
    spurious = 0;
    budget = 0;
    while (!init_done && budget < 40) begin
      if (rsp_valid != '0) spurious++;
      @(posedge clk); @(negedge clk);
      budget++;
    end
    check("rr_rst_redone", 64'(init_done), 64'd1);
    check("rr_rst_no_rsp", 64'(spurious), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
